bf_prog_loader: RTL and testbench

Program loader between the UART receiver and the program-memory write port of the TinyBF core. While programming mode is active it consumes received ASCII bytes, drops non-Brainfuck characters, and run-length-compresses `+ - > <` into 8-bit instruction words. It writes the words sequentially from address 0 and finishes with an END word. It also reports overflow and bracket-balance errors, and asserts busy, which feeds the board-level busy pin.

---
 rtl/bf_prog_loader.sv | 178 +++++++++++++++++
 tb/tb_bf_prog_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bf_prog_loader.sv
// Brainfuck program loader: filters UART bytes, run-length packs + - > <,
// and streams 8-bit instruction words into program memory ending with END.
module bf_prog_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              prog_mode_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              busy_o,
  output logic [ADDR_W:0]   prog_len_o,
  output logic              overflow_o,
  output logic              bracket_err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_ENDW  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [DATA_W-1:0] END_W = '1;
  localparam logic [ADDR_W:0]   ONE   = 1;
  localparam logic [ADDR_W:0]   DMAX  = '1;

  logic [2:0]        state, state_n;
  logic              mode_q, mode_q2;
  logic              rise, fall;
  logic              pv, pv_n;
  logic [2:0]        po, po_n;
  logic [4:0]        pc, pc_n;
  logic [ADDR_W:0]   depth, depth_n;
  logic              berr_set;
  logic              wr;
  logic [DATA_W-1:0] wr_word;
  logic              is_bf, is_term;
  logic [2:0]        op;
  logic              full;

  assign rise    = mode_q & ~mode_q2;
  assign fall    = ~mode_q & mode_q2;
  assign is_term = (rx_data_i == 8'h21);
  assign full    = prog_len_o[ADDR_W];

  always_comb begin
    is_bf = 1'b1;
    op    = 3'd0;
    case (rx_data_i)
      8'h3E:   op = 3'd0;
      8'h3C:   op = 3'd1;
      8'h2B:   op = 3'd2;
      8'h2D:   op = 3'd3;
      8'h2E:   op = 3'd4;
      8'h2C:   op = 3'd5;
      8'h5B:   op = 3'd6;
      8'h5D:   op = 3'd7;
      default: is_bf = 1'b0;
    endcase
  end

  always_comb begin
    state_n  = state;
    pv_n     = pv;
    po_n     = po;
    pc_n     = pc;
    depth_n  = depth;
    berr_set = 1'b0;
    wr       = 1'b0;
    wr_word  = {po, pc};
    if (rise) begin
      state_n = S_LOAD;
      pv_n    = 1'b0;
      depth_n = '0;
    end else begin
      unique case (state)
        S_LOAD: begin
          if (rx_valid_i && is_bf) begin
            if (!op[2] && pv && po == op && pc != 5'd31) begin
              pc_n = pc + 5'd1;
            end else begin
              wr   = pv;
              pv_n = 1'b1;
              po_n = op;
              pc_n = 5'd0;
            end
            if (op == 3'd6 && depth != DMAX)
              depth_n = depth + ONE;
            if (op == 3'd7) begin
              if (depth == '0) berr_set = 1'b1;
              else depth_n = depth - ONE;
            end
          end
          if ((rx_valid_i && is_term) || fall) begin
            // a char landing with the mode drop is still owed a slot
            if (rx_valid_i && is_bf) begin
              state_n = S_FLUSH;
            end else if (pv) begin
              wr      = 1'b1;
              pv_n    = 1'b0;
              state_n = S_ENDW;
            end else begin
              wr       = 1'b1;
              wr_word  = END_W;
              berr_set = (depth != '0);
              state_n  = S_DONE;
            end
          end
        end
        S_FLUSH: begin
          wr      = pv;
          pv_n    = 1'b0;
          state_n = S_ENDW;
        end
        S_ENDW: begin
          wr       = 1'b1;
          wr_word  = END_W;
          berr_set = (depth != '0);
          state_n  = S_DONE;
        end
        S_IDLE, S_DONE: ;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= S_IDLE;
      mode_q        <= 1'b0;
      mode_q2       <= 1'b0;
      pv            <= 1'b0;
      po            <= 3'd0;
      pc            <= 5'd0;
      depth         <= '0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      busy_o        <= 1'b0;
      prog_len_o    <= '0;
      overflow_o    <= 1'b0;
      bracket_err_o <= 1'b0;
    end else begin
      mode_q   <= prog_mode_i;
      mode_q2  <= mode_q;
      state    <= state_n;
      pv       <= pv_n;
      po       <= po_n;
      pc       <= pc_n;
      depth    <= depth_n;
      mem_we_o <= 1'b0;
      if (rise) begin
        prog_len_o    <= '0;
        overflow_o    <= 1'b0;
        bracket_err_o <= 1'b0;
        busy_o        <= 1'b1;
      end else begin
        if (berr_set) bracket_err_o <= 1'b1;
        if (state == S_DONE) busy_o <= 1'b0;
        if (wr) begin
          if (full) begin
            overflow_o <= 1'b1;
          end else begin
            mem_we_o    <= 1'b1;
            mem_addr_o  <= prog_len_o[ADDR_W-1:0];
            mem_wdata_o <= wr_word;
            prog_len_o  <= prog_len_o + ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bf_prog_loader.sv
// Directed bench for bf_prog_loader: captures memory writes and
// compares them with hand-encoded instruction streams.
module tb_bf_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       prog_mode = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       busy;
  logic [5:0] prog_len;
  logic       overflow;
  logic       bracket_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] wa[$];
  logic [7:0] wd[$];
  logic [7:0] exp_q[$];

  bf_prog_loader #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .prog_mode_i  (prog_mode),
    .rx_valid_i   (rx_valid),
    .rx_data_i    (rx_data),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .busy_o       (busy),
    .prog_len_o   (prog_len),
    .overflow_o   (overflow),
    .bracket_err_o(bracket_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic start();
    prog_mode = 1'b0;
    repeat (3) @(negedge clk);
    wa.delete();
    wd.delete();
    prog_mode = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = s[i];
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 100; k++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_words(input string tag);
    check({tag, "_nwr"}, wa.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < wa.size()) begin
        check($sformatf("%s_a%0d", tag, i), {27'd0, wa[i]}, i);
        check($sformatf("%s_d%0d", tag, i), {24'd0, wd[i]},
              {24'd0, exp_q[i]});
      end
    end
  endtask

  initial begin
    string s;
    repeat (2) @(negedge clk);
    check("rst_we", {31'd0, mem_we}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_len", {26'd0, prog_len}, 0);
    check("rst_ovf", {31'd0, overflow}, 0);
    check("rst_berr", {31'd0, bracket_err}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // spaces/newlines must not break a run
    start();
    check("t1_busy", {31'd0, busy}, 1);
    send_str("+ +\n+>.!");
    wait_done("t1");
    exp_q = {8'h42, 8'h00, 8'h80, 8'hFF};
    chk_words("t1");
    check("t1_len", {26'd0, prog_len}, 4);
    check("t1_berr", {31'd0, bracket_err}, 0);
    check("t1_ovf", {31'd0, overflow}, 0);

    start();
    s = "";
    for (int i = 0; i < 40; i++) s = {s, "-"};
    s = {s, "!"};
    send_str(s);
    wait_done("t2");
    exp_q = {8'h7F, 8'h67, 8'hFF};
    chk_words("t2");
    check("t2_len", {26'd0, prog_len}, 3);

    start();
    send_str("[+]");
    prog_mode = 1'b0;
    wait_done("t3");
    exp_q = {8'hC0, 8'h40, 8'hE0, 8'hFF};
    chk_words("t3");
    check("t3_berr", {31'd0, bracket_err}, 0);

    start();
    send_str("]!");
    wait_done("t4");
    exp_q = {8'hE0, 8'hFF};
    chk_words("t4");
    check("t4_berr", {31'd0, bracket_err}, 1);

    start();
    send_str("[[+]!");
    wait_done("t5");
    exp_q = {8'hC0, 8'hC0, 8'h40, 8'hE0, 8'hFF};
    chk_words("t5");
    check("t5_berr", {31'd0, bracket_err}, 1);

    start();
    s = "";
    for (int i = 0; i < 33; i++) s = {s, (i % 2 == 0) ? "." : ","};
    s = {s, "!"};
    send_str(s);
    wait_done("t6");
    check("t6_nwr", wa.size(), 32);
    if (wa.size() == 32) begin
      check("t6_last_a", {27'd0, wa[31]}, 31);
      check("t6_last_d", {24'd0, wd[31]}, 32'hA0);
      check("t6_d0", {24'd0, wd[0]}, 32'h80);
    end
    check("t6_len", {26'd0, prog_len}, 32);
    check("t6_ovf", {31'd0, overflow}, 1);

    // reset lands while a write strobe is high
    start();
    send_str("+>");
    check("t7_pre_we", {31'd0, mem_we}, 1);
    rst = 1'b0;
    #1;
    check("t7_we", {31'd0, mem_we}, 0);
    check("t7_busy", {31'd0, busy}, 0);
    check("t7_len", {26'd0, prog_len}, 0);
    check("t7_addr", {27'd0, mem_addr}, 0);
    check("t7_wdata", {24'd0, mem_wdata}, 0);
    @(negedge clk);
    rst = 1'b1;
    start();
    send_str("+!");
    wait_done("t8");
    exp_q = {8'h40, 8'hFF};
    chk_words("t8");
    check("t8_len", {26'd0, prog_len}, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
